dds_sine_gen: RTL and testbench
===============================

# dds_sine_gen

Parametrised direct-digital-synthesis sine generator. It is the next generation of the team's phase-accumulator plus unsigned-ROM sine source. It adds:
- configurable phase, table and output widths
- a quarter-wave table with symmetry folding
- a programmable phase offset
- a ready/valid configuration port with optional phase-continuous (wrap-synchronous) update
- sample enable, resync clear and a pipelined output with valid

It feeds the team's modulation and test-tone paths.

## Interface

- PHASE_W, 24: accumulator, frequency-word and phase-offset width.
- LUT_AW, 8: quarter-wave table address width (2^LUT_AW entries).
- DATA_W, 12: output sample width.
- OUT_SIGNED, 1: 1 = two's complement output; 0 = offset binary (signed value with MSB inverted).
- SYNC_UPD, 1: 1 = pending config applied at accumulator wrap; 0 = applied on the next enabled cycle.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; accumulator advances only when high.
- sync_clr  in  1  synchronous accumulator clear (resync).
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- cfg_freq  in  PHASE_W  new frequency (phase-increment) word.
- cfg_phase  in  PHASE_W  new phase-offset word.
- dout  out  DATA_W  sine sample.
- dout_valid  out  1  dout carries a new sample this cycle.

## Operation

- Registers: acc, freq, poff (PHASE_W each); pend_freq, pend_phase, pend flag.
- Reset values:
  - acc, freq, poff and pend are 0.
  - All pipeline registers are 0; dout = 0 and dout_valid = 0 in both modes.
  - cfg_ready = 1.
- Config handshake:
  - cfg_ready = !pend.
  - On accept, the words are latched into pend_* and pend is set.
  - cfg_valid while pend is high is ignored and held off by the master.
- Apply:
  - Applying a config loads freq/poff from pend_* and clears pend, so cfg_ready returns to 1 the following cycle.
  - SYNC_UPD=1: apply on an enabled cycle whose acc+freq carries out of PHASE_W (wrap). The new freq takes effect from the next increment.
  - SYNC_UPD=0: apply on the first enabled cycle after accept.
  - An apply also occurs on any sync_clr cycle (enabled or not).
- Accumulator:
  - If sync_clr: acc <= 0.
  - Else if en: acc <= acc + freq (mod 2^PHASE_W). The wrap condition is computed with the old freq.
  - Else acc holds.
  - sync_clr has priority over en.
- Phase: ph = acc + poff (mod 2^PHASE_W); q = ph[PHASE_W-1:PHASE_W-2]; idx = ph[PHASE_W-3 -: LUT_AW].
- Fold: if q[0], addr = ~idx; else addr = idx.
- Table: Q[k] = round((2^(DATA_W-1)-1)·sin(π/2·(k+0.5)/2^LUT_AW)).
  - Initialised at elaboration from this formula; no external file.
  - The half-step offset gives exact odd/even symmetry.
- Sign: if q[1], s = -Q[addr]; else s = Q[addr]. Magnitude never exceeds 2^(DATA_W-1)-1, so negation cannot overflow.
- Output: dout = s when OUT_SIGNED; otherwise dout = {~s[DATA_W-1], s[DATA_W-2:0]}.

## Timing

- Three-stage pipeline, each with a valid bit:
  - S1 registers ph; valid = en && !sync_clr in the cycle acc was sampled.
  - S2 registers Q[addr], q[1].
  - S3 registers dout, dout_valid.
- A stage updates data only when its incoming valid is 1; otherwise its data holds and valid drops.
- dout holds its last sample while dout_valid = 0.
- Latency: the sample for acc value A (with poff P) appears on dout 3 rising edges after A is present in acc.
- Continuous en: one sample per clock, dout_valid constantly 1 after fill.
- poff change takes effect in S1 on the edge after apply; no glitch samples, no sample dropped.
- Phase-continuous update (SYNC_UPD=1): the frequency switch lands on the sample following the wrap, with no discontinuity in acc.
- Reset mid-operation: all state returns to reset values asynchronously. The first sample after release is Q at phase poff=0, i.e. dout = Q[0].
- Accept and apply in the same cycle (SYNC_UPD=0, en=1, cfg_valid=1 with pend=0): accept only; apply happens the next enabled cycle.

## Test plan

Default parameters (PHASE_W=24, LUT_AW=8, DATA_W=12, OUT_SIGNED=1, SYNC_UPD=1) unless stated.

1. Reset, then cfg_freq=0x400000, cfg_phase=0, apply via sync_clr pulse, en=1 -> after 3-cycle fill dout repeats 6, 2047, -6, -2047 with dout_valid=1 each cycle.
2. Same stimulus with OUT_SIGNED=0 -> dout repeats 2054, 4095, 2042, 1.
3. freq=0x400000 running, issue cfg_freq=0x200000 at acc=0x400000 (SYNC_UPD=1) -> cfg_ready low, freq changes only after acc wraps through 0. The next acc values are 0x200000, 0x400000; cfg_ready=1 the cycle after apply.
4. freq=0x400000, cfg_phase=0x400000 with SYNC_UPD=0 -> output sequence shifted one sample (2047, -6, -2047, 6) from the second enabled cycle after accept, no repeated or missing sample.
5. Toggle en low for 5 cycles mid-stream -> dout_valid drops after 3-cycle drain, dout holds its last value, acc frozen. Sequence resumes exactly where it stopped.
6. Assert rst low during streaming with pend=1 -> dout=0, dout_valid=0, cfg_ready=1 immediately. After release with en=1 and freq=0, dout_valid=1 from the 3rd edge and dout is constant 6.

Source files
------------

// File: rtl/dds_sine_gen.sv
// dds_sine_gen: phase-accumulator DDS with a quarter-wave sine table,
// programmable phase offset, ready/valid configuration port and a
// three-stage output pipeline with valid.
module dds_sine_gen #(
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 8,
  parameter int DATA_W     = 12,
  parameter bit OUT_SIGNED = 1'b1,
  parameter bit SYNC_UPD   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [PHASE_W-1:0] cfg_phase,
  output logic [DATA_W-1:0]  dout,
  output logic               dout_valid
);

  localparam int LUT_N   = 2 ** LUT_AW;
  localparam int IDX_LSB = PHASE_W - 2 - LUT_AW;
  localparam real AMP    = real'((2 ** (DATA_W - 1)) - 1);
  localparam real HALF_PI = 1.57079632679489661923;

  // Quarter-wave entry k, sampled at the centre of its bin so that the
  // folded quadrants are exact mirror images of each other.
  function automatic logic [DATA_W-2:0] qval(input int k);
    real x;
    x = AMP * $sin(HALF_PI * (real'(k) + 0.5) / real'(LUT_N));
    return (DATA_W-1)'($rtoi(x + 0.5));
  endfunction

  logic [DATA_W-2:0] rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    assign rom[k] = qval(k);
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] freq;
  logic [PHASE_W-1:0] poff;
  logic [PHASE_W-1:0] pend_freq;
  logic [PHASE_W-1:0] pend_phase;
  logic               pend;

  logic [PHASE_W:0]   acc_sum;
  logic               wrap;
  logic               accept;
  logic               apply;
  logic               s1_load;

  logic [LUT_AW+1:0]  ph_top;
  logic [IDX_LSB-1:0] ph_lo_unused;

  logic               s1_valid;
  logic [LUT_AW+1:0]  s1_ph;
  logic [1:0]         s1_q;
  logic [LUT_AW-1:0]  s1_idx;
  logic [LUT_AW-1:0]  s1_addr;

  logic               s2_valid;
  logic               s2_neg;
  logic [DATA_W-2:0]  s2_mag;
  logic [DATA_W-1:0]  s2_s;
  logic [DATA_W-1:0]  s2_out;

  assign cfg_ready = !pend;

  // Carry out of acc+freq (old freq) marks the wrap; decide accept/apply.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, freq};
    wrap    = acc_sum[PHASE_W];
    accept  = cfg_valid && !pend;
    apply   = pend && (sync_clr || (en && (!SYNC_UPD || wrap)));
    s1_load = en && !sync_clr;
  end

  // Only the quadrant and table-index bits of the phase reach the table.
  assign {ph_top, ph_lo_unused} = acc + poff;

  // Configuration staging: latch on accept, move to live registers on apply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= 1'b0;
      pend_freq  <= '0;
      pend_phase <= '0;
      freq       <= '0;
      poff       <= '0;
    end else if (apply) begin
      freq <= pend_freq;
      poff <= pend_phase;
      pend <= 1'b0;
    end else if (accept) begin
      pend_freq  <= cfg_freq;
      pend_phase <= cfg_phase;
      pend       <= 1'b1;
    end
  end

  // Phase accumulator: clear has priority over advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (sync_clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum[PHASE_W-1:0];
    end
  end

  // Stage 1: capture the offset phase of the current accumulator value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_ph    <= '0;
    end else begin
      s1_valid <= s1_load;
      if (s1_load) s1_ph <= ph_top;
    end
  end

  // Quadrant fold: odd quadrants read the table backwards.
  always_comb begin
    s1_q    = s1_ph[LUT_AW+1:LUT_AW];
    s1_idx  = s1_ph[LUT_AW-1:0];
    s1_addr = s1_q[0] ? ~s1_idx : s1_idx;
  end

  // Stage 2: table lookup plus the sign of the half-wave.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_mag   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mag <= rom[s1_addr];
        s2_neg <= s1_q[1];
      end
    end
  end

  // Apply the sign, then optionally convert to offset binary.
  always_comb begin
    s2_s = {1'b0, s2_mag};
    if (s2_neg) s2_s = -s2_s;
    s2_out = OUT_SIGNED ? s2_s : {~s2_s[DATA_W-1], s2_s[DATA_W-2:0]};
  end

  // Stage 3: output register; holds the last sample while not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s2_valid;
      if (s2_valid) dout <= s2_out;
    end
  end

endmodule

// File: tb/tb_dds_sine_gen.sv
// tb_dds_sine_gen: three DDS instances (default, offset-binary output,
// immediate config update) driven by shared stimulus and checked every
// cycle against a transaction-level sine model.
module tb_dds_sine_gen;

  localparam int PW = 24;
  localparam int AW = 8;
  localparam int DW = 12;
  localparam int unsigned MASK = 32'h00FF_FFFF;
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = 2047.0;
  localparam bit P_SYNC   [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit P_SIGNED [3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic sync_clr = 1'b0;
  logic cfg_valid = 1'b0;
  logic [PW-1:0] cfg_freq = '0;
  logic [PW-1:0] cfg_phase = '0;

  logic rdy_m, rdy_o, rdy_a;
  logic dv_m, dv_o, dv_a;
  logic [DW-1:0] dout_m, dout_o, dout_a;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dds_sine_gen #(.PHASE_W(PW), .LUT_AW(AW), .DATA_W(DW), .OUT_SIGNED(1'b1), .SYNC_UPD(1'b1)) u_main (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .cfg_valid(cfg_valid), .cfg_ready(rdy_m),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .dout(dout_m), .dout_valid(dv_m));

  dds_sine_gen #(.PHASE_W(PW), .LUT_AW(AW), .DATA_W(DW), .OUT_SIGNED(1'b0), .SYNC_UPD(1'b1)) u_ob (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .cfg_valid(cfg_valid), .cfg_ready(rdy_o),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .dout(dout_o), .dout_valid(dv_o));

  dds_sine_gen #(.PHASE_W(PW), .LUT_AW(AW), .DATA_W(DW), .OUT_SIGNED(1'b1), .SYNC_UPD(1'b0)) u_async (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .cfg_valid(cfg_valid), .cfg_ready(rdy_a),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .dout(dout_a), .dout_valid(dv_a));

  // Reference state per instance.
  int unsigned m_acc [3];
  int unsigned m_freq [3];
  int unsigned m_poff [3];
  int unsigned m_pf [3];
  int unsigned m_pp [3];
  bit          m_pend [3];
  bit          dl_v [3][3];
  logic [DW-1:0] dl_s [3][3];
  logic [DW-1:0] m_dout [3];
  bit          m_dv [3];

  // Ideal sine sampled at the centre of the phase bin that selects the entry.
  function automatic logic [DW-1:0] sine_ref(input int unsigned ph, input bit sgn);
    int unsigned bin;
    real ang, v, av;
    int m, s;
    bin = ph >> (PW - AW - 2);
    ang = 2.0 * PI * (real'(bin) + 0.5) / real'(4 * (1 << AW));
    v = $sin(ang);
    av = (v < 0.0) ? -v : v;
    m = $rtoi(AMP * av + 0.5);
    s = (v < 0.0) ? -m : m;
    if (sgn) return DW'(s);
    return DW'(s + (1 << (DW - 1)));
  endfunction

  task automatic model_reset(input int i);
    m_acc[i] = 0; m_freq[i] = 0; m_poff[i] = 0; m_pf[i] = 0; m_pp[i] = 0;
    m_pend[i] = 1'b0; m_dout[i] = '0; m_dv[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dl_v[i][k] = 1'b0;
      dl_s[i][k] = '0;
    end
  endtask

  task automatic model_update(input int i);
    longint sum;
    bit wrap, accept, apply;
    sum = longint'(m_acc[i]) + longint'(m_freq[i]);
    wrap = (sum > longint'(MASK));
    accept = cfg_valid && !m_pend[i];
    apply = m_pend[i] && (sync_clr || (en && (!P_SYNC[i] || wrap)));
    dl_v[i][0] = dl_v[i][1]; dl_s[i][0] = dl_s[i][1];
    dl_v[i][1] = dl_v[i][2]; dl_s[i][1] = dl_s[i][2];
    dl_v[i][2] = en && !sync_clr;
    dl_s[i][2] = sine_ref((m_acc[i] + m_poff[i]) & MASK, P_SIGNED[i]);
    m_dv[i] = dl_v[i][0];
    if (dl_v[i][0]) m_dout[i] = dl_s[i][0];
    if (sync_clr) m_acc[i] = 0;
    else if (en) m_acc[i] = int'(sum) & MASK;
    if (apply) begin
      m_freq[i] = m_pf[i];
      m_poff[i] = m_pp[i];
      m_pend[i] = 1'b0;
    end else if (accept) begin
      m_pf[i] = int'(cfg_freq);
      m_pp[i] = int'(cfg_phase);
      m_pend[i] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("dout_main", 32'(dout_m), 32'(m_dout[0]));
    chk("dv_main", 32'(dv_m), 32'(m_dv[0]));
    chk("rdy_main", 32'(rdy_m), 32'(!m_pend[0]));
    chk("dout_ob", 32'(dout_o), 32'(m_dout[1]));
    chk("dv_ob", 32'(dv_o), 32'(m_dv[1]));
    chk("rdy_ob", 32'(rdy_o), 32'(!m_pend[1]));
    chk("dout_async", 32'(dout_a), 32'(m_dout[2]));
    chk("dv_async", 32'(dv_a), 32'(m_dv[2]));
    chk("rdy_async", 32'(rdy_a), 32'(!m_pend[2]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst) model_reset(i);
      else model_update(i);
    end
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] seq_s [4];
    logic [DW-1:0] seq_o [4];
    seq_s = '{12'h006, 12'h7FF, 12'hFFA, 12'h801};
    seq_o = '{12'd2054, 12'd4095, 12'd2042, 12'd1};

    // Reset state.
    repeat (2) step();
    chk("reset_dout", 32'(dout_m), 32'h0);
    chk("reset_dv", 32'(dv_m), 32'h0);
    chk("reset_rdy", 32'(rdy_m), 32'h1);
    rst = 1'b1;
    step();

    // Quarter-rate tone applied by a resync pulse.
    cfg_valid = 1'b1; cfg_freq = 24'h400000; cfg_phase = '0;
    step();
    cfg_valid = 1'b0;
    chk("accept_rdy_low", 32'(rdy_m), 32'h0);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    en = 1'b1;
    repeat (2) step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("tone_signed", 32'(dout_m), 32'(seq_s[k % 4]));
      chk("tone_offset", 32'(dout_o), 32'(seq_o[k % 4]));
      chk("tone_valid", 32'(dv_m), 32'h1);
    end

    // Wrap-synchronous frequency change issued at acc=0x400000.
    repeat (3) step();
    cfg_valid = 1'b1; cfg_freq = 24'h200000; cfg_phase = '0;
    step();
    cfg_valid = 1'b0;
    chk("sync_pend_a", 32'(rdy_m), 32'h0);
    step();
    chk("sync_pend_b", 32'(rdy_m), 32'h0);
    step();
    chk("sync_applied", 32'(rdy_m), 32'h1);
    repeat (10) step();

    // Phase offset change.
    cfg_valid = 1'b1; cfg_freq = 24'h400000; cfg_phase = 24'h400000;
    step();
    cfg_valid = 1'b0;
    repeat (14) step();

    // Enable gap.
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (10) step();

    // Randomized operation.
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 49) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_freq = PW'($urandom());
      cfg_phase = PW'($urandom());
      step();
    end
    cfg_valid = 1'b0;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    en = 1'b1;
    repeat (5) step();

    // Reset mid-stream with a config pending.
    cfg_valid = 1'b1; cfg_freq = '0; cfg_phase = 24'h123456;
    step();
    cfg_valid = 1'b0;
    en = 1'b0;
    chk("pre_rst_pend", 32'(rdy_m), 32'h0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    check_all();
    chk("async_rst_dout", 32'(dout_m), 32'h0);
    chk("async_rst_dv", 32'(dv_m), 32'h0);
    chk("async_rst_rdy", 32'(rdy_m), 32'h1);
    step();
    rst = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_dv", 32'(dv_m), (k == 2) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_dout", 32'(dout_m), 32'h006);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
